// File: rtl/rpn_from_network_bridge_ingress_filter.sv
// Registered AXIS ingress filter: 2-entry skid buffer, RPN msg-type check.
// Optional packet length limit under `RPN_INGRESS_MAX_LEN_CHECK_EN.
module rpn_from_network_bridge_ingress_filter #(
  parameter int AXIS_DATA_WIDTH          = 64,
  parameter int AXIS_KEEP_WIDTH          = 8,
  parameter int AXIS_FROM_NB_TDEST_WIDTH = 16,
  parameter int AXIS_FROM_NB_TUSER_WIDTH = 16,
  parameter int RPN_MSG_TYPE_WIDTH       = 8,
  parameter int RPN_MSG_TYPE_MAX         = 8,
  parameter int DROP_CNT_WIDTH           = 16,
  parameter int MAX_PKT_BEATS            = 16
) (
  input  logic                                i_clk,
  input  logic                                i_ap_rst,
  input  logic                                from_network_bridge_tvalid,
  output logic                                from_network_bridge_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]          from_network_bridge_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]          from_network_bridge_tkeep,
  input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_network_bridge_tid,
  input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_network_bridge_tdest,
  input  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] from_network_bridge_tuser,
  input  logic                                from_network_bridge_tlast,
  output logic                                to_splitter_tvalid,
  input  logic                                to_splitter_tready,
  output logic [AXIS_DATA_WIDTH-1:0]          to_splitter_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]          to_splitter_tkeep,
  output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_splitter_tid,
  output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_splitter_tdest,
  output logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_splitter_tuser,
  output logic                                to_splitter_tlast,
  output logic [DROP_CNT_WIDTH-1:0]           o_drop_cnt,
  output logic                                o_drop_pulse,
  output logic [DROP_CNT_WIDTH-1:0]           o_trunc_cnt
);

  localparam int BEAT_W = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH
                        + 2 * AXIS_FROM_NB_TDEST_WIDTH
                        + AXIS_FROM_NB_TUSER_WIDTH + 1;

  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] TYPE_MAX =
    RPN_MSG_TYPE_WIDTH'(RPN_MSG_TYPE_MAX);

  if (MAX_PKT_BEATS < 1 ||
      AXIS_KEEP_WIDTH * 8 != AXIS_DATA_WIDTH) begin : g_param_chk
    $error("ingress filter: inconsistent parameters");
  end

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] push_beat;
  logic [BEAT_W-1:0] out_q;
  logic [BEAT_W-1:0] out_d;
  logic [BEAT_W-1:0] skid_q;
  logic [BEAT_W-1:0] skid_d;
  logic              out_vld_q;
  logic              out_vld_d;
  logic              skid_vld_q;
  logic              skid_vld_d;
  logic              ready_q;
  logic              ready_d;
  logic [1:0]        occ_d;
  logic              in_fire;
  logic              out_fire;
  logic              head_legal;
  logic              push;
  logic              drop_start;
  logic              at_limit;
  logic              force_last;

  assign in_beat = {from_network_bridge_tdata,
                    from_network_bridge_tkeep,
                    from_network_bridge_tid,
                    from_network_bridge_tdest,
                    from_network_bridge_tuser,
                    from_network_bridge_tlast};

  assign in_fire  = from_network_bridge_tvalid & ready_q;
  assign out_fire = out_vld_q & to_splitter_tready;

  assign head_legal =
    (from_network_bridge_tdata[RPN_MSG_TYPE_WIDTH-1:0] <= TYPE_MAX) &&
    from_network_bridge_tkeep[0];

  assign force_last = push & at_limit;
  assign push_beat  = {in_beat[BEAT_W-1:1], in_beat[0] | force_last};

  // Packet framing FSM: decide push/discard for each accepted beat
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    drop_start = 1'b0;
    if (in_fire) begin
      unique case (state_q)
        HEAD: begin
          if (head_legal) begin
            push = 1'b1;
            if (!from_network_bridge_tlast) state_d = BODY;
          end else begin
            drop_start = 1'b1;
            if (!from_network_bridge_tlast) state_d = DROP;
          end
        end
        BODY: begin
          push = 1'b1;
          if (from_network_bridge_tlast) state_d = HEAD;
        end
        DROP: begin
          if (from_network_bridge_tlast) state_d = HEAD;
        end
        default: state_d = HEAD;
      endcase
      if (push && at_limit && !from_network_bridge_tlast) state_d = DROP;
    end
  end

  // Skid buffer next state; input ready is precomputed for next cycle
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (out_fire || !out_vld_q) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = push;
        if (push) skid_d = push_beat;
      end else begin
        out_vld_d = push;
        if (push) out_d = push_beat;
      end
    end else if (push) begin
      skid_d     = push_beat;
      skid_vld_d = 1'b1;
    end
    occ_d   = {1'b0, out_vld_d} + {1'b0, skid_vld_d};
    ready_d = (occ_d != 2'd2) || (state_d == DROP);
  end

  // State, buffer, ready and drop statistics registers
  always_ff @(posedge i_clk) begin
    if (i_ap_rst) begin
      state_q      <= HEAD;
      out_q        <= '0;
      skid_q       <= '0;
      out_vld_q    <= 1'b0;
      skid_vld_q   <= 1'b0;
      ready_q      <= 1'b0;
      o_drop_cnt   <= '0;
      o_drop_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_vld_q    <= out_vld_d;
      skid_vld_q   <= skid_vld_d;
      ready_q      <= ready_d;
      o_drop_pulse <= drop_start;
      if (drop_start && (o_drop_cnt != '1))
        o_drop_cnt <= o_drop_cnt + DROP_CNT_WIDTH'(1);
    end
  end

`ifdef RPN_INGRESS_MAX_LEN_CHECK_EN
  localparam int BCNT_W = $clog2(MAX_PKT_BEATS + 1);

  logic [BCNT_W-1:0] bcnt_q;
  logic [BCNT_W-1:0] beat_num;
  logic              trunc_hit;

  assign beat_num  = (state_q == HEAD) ? BCNT_W'(1)
                                       : bcnt_q + BCNT_W'(1);
  assign at_limit  = (beat_num == BCNT_W'(MAX_PKT_BEATS));
  assign trunc_hit = push & at_limit & ~from_network_bridge_tlast;

  // Beat position within the forwarded packet and truncation count
  always_ff @(posedge i_clk) begin
    if (i_ap_rst) begin
      bcnt_q      <= '0;
      o_trunc_cnt <= '0;
    end else begin
      if (push) bcnt_q <= beat_num;
      if (trunc_hit && (o_trunc_cnt != '1))
        o_trunc_cnt <= o_trunc_cnt + DROP_CNT_WIDTH'(1);
    end
  end
`else
  assign at_limit    = 1'b0;
  assign o_trunc_cnt = '0;
`endif

  assign from_network_bridge_tready = ready_q;
  assign to_splitter_tvalid         = out_vld_q;
  assign {to_splitter_tdata,
          to_splitter_tkeep,
          to_splitter_tid,
          to_splitter_tdest,
          to_splitter_tuser,
          to_splitter_tlast} = out_q;

endmodule

// File: tb/tb_rpn_from_network_bridge_ingress_filter.sv
// Directed bench for the RPN ingress filter: vector table plus
// hand sequences for stall, reset and length-limit corner cases.
module tb_rpn_from_network_bridge_ingress_filter;

  localparam int DW   = 64;
  localparam int KW   = 8;
  localparam int TW   = 16;
  localparam int UW   = 16;
  localparam int CW   = 4;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          nb_tvalid = 1'b0;
  logic          nb_tready;
  logic [DW-1:0] nb_tdata = '0;
  logic [KW-1:0] nb_tkeep = '0;
  logic [TW-1:0] nb_tid = '0;
  logic [TW-1:0] nb_tdest = '0;
  logic [UW-1:0] nb_tuser = '0;
  logic          nb_tlast = 1'b0;
  logic          sp_tvalid;
  logic          sp_tready = 1'b1;
  logic [DW-1:0] sp_tdata;
  logic [KW-1:0] sp_tkeep;
  logic [TW-1:0] sp_tid;
  logic [TW-1:0] sp_tdest;
  logic [UW-1:0] sp_tuser;
  logic          sp_tlast;
  logic [CW-1:0] drop_cnt;
  logic          drop_pulse;
  logic [CW-1:0] trunc_cnt;

  always #5 clk = ~clk;

  rpn_from_network_bridge_ingress_filter #(
    .AXIS_DATA_WIDTH(DW),
    .AXIS_KEEP_WIDTH(KW),
    .AXIS_FROM_NB_TDEST_WIDTH(TW),
    .AXIS_FROM_NB_TUSER_WIDTH(UW),
    .RPN_MSG_TYPE_WIDTH(8),
    .RPN_MSG_TYPE_MAX(8),
    .DROP_CNT_WIDTH(CW),
    .MAX_PKT_BEATS(MAXB)
  ) dut (
    .i_clk(clk),
    .i_ap_rst(rst),
    .from_network_bridge_tvalid(nb_tvalid),
    .from_network_bridge_tready(nb_tready),
    .from_network_bridge_tdata(nb_tdata),
    .from_network_bridge_tkeep(nb_tkeep),
    .from_network_bridge_tid(nb_tid),
    .from_network_bridge_tdest(nb_tdest),
    .from_network_bridge_tuser(nb_tuser),
    .from_network_bridge_tlast(nb_tlast),
    .to_splitter_tvalid(sp_tvalid),
    .to_splitter_tready(sp_tready),
    .to_splitter_tdata(sp_tdata),
    .to_splitter_tkeep(sp_tkeep),
    .to_splitter_tid(sp_tid),
    .to_splitter_tdest(sp_tdest),
    .to_splitter_tuser(sp_tuser),
    .to_splitter_tlast(sp_tlast),
    .o_drop_cnt(drop_cnt),
    .o_drop_pulse(drop_pulse),
    .o_trunc_cnt(trunc_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [TW-1:0] id;
    logic [TW-1:0] dest;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    logic [7:0]    typ;
    logic [KW-1:0] keep;
    logic [55:0]   hi;
    bit            fwd;
    int            cnt;
  } vec_t;

  beat_t exp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    pulses = 0;
  int    stalls = 0;
  int    outs = 0;
  int    ds_mode = 0;
  bit    tog = 1'b1;
  bit    rdy_chk = 1'b0;
  int    occ_m = 0;
  bit    held_vld = 1'b0;
  beat_t held;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic beat_t mk(input logic [7:0] typ,
                               input logic [KW-1:0] keep,
                               input logic last);
    beat_t b;
    b.data      = {$urandom(), $urandom()};
    b.data[7:0] = typ;
    b.keep      = keep;
    b.id        = TW'($urandom());
    b.dest      = TW'($urandom());
    b.user      = UW'($urandom());
    b.last      = last;
    return b;
  endfunction

  // Downstream ready pattern, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    case (ds_mode)
      0: sp_tready = 1'b1;
      1: sp_tready = 1'b0;
      default: begin
        sp_tready = tog;
        tog = ~tog;
      end
    endcase
  end

  // Output monitor: scoreboard, stall stability, ready model
  always @(negedge clk) begin
    beat_t cur;
    cur = {sp_tdata, sp_tkeep, sp_tid, sp_tdest, sp_tuser, sp_tlast};
    if (rst) begin
      held_vld = 1'b0;
    end else begin
      if (drop_pulse) pulses++;
      if (sp_tvalid) begin
        if (held_vld) check("stall_hold", 128'(cur), 128'(held));
        if (sp_tready) begin
          outs++;
          held_vld = 1'b0;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h, expected none",
                     cur);
          end else begin
            check("out_beat", 128'(cur), 128'(exp_q.pop_front()));
          end
        end else begin
          held     = cur;
          held_vld = 1'b1;
        end
      end else begin
        if (held_vld) check("stall_valid", 128'(sp_tvalid), 128'(1));
        held_vld = 1'b0;
      end
      if (rdy_chk) begin
        check("rdy_vs_occ", 128'(nb_tready), 128'(occ_m < 2));
        occ_m = occ_m + int'(nb_tvalid && nb_tready)
                      - int'(sp_tvalid && sp_tready);
      end
    end
  end

  task automatic drive(input beat_t b, input bit fwd, input bit flast);
    beat_t e;
    @(posedge clk);
    #1;
    nb_tvalid = 1'b1;
    {nb_tdata, nb_tkeep, nb_tid, nb_tdest, nb_tuser, nb_tlast} = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (nb_tready) begin
        e = b;
        e.last = b.last | flast;
        if (fwd) exp_q.push_back(e);
        return;
      end
      stalls++;
    end
    n_chk++;
    n_fail++;
    $display("FAIL drive_timeout: tready=%0b, expected 1", nb_tready);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    nb_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !sp_tvalid) break;
    end
    @(negedge clk);
    check("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic reset_seq(input string tag);
    @(posedge clk);
    #1;
    nb_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rst_tvalid"}, 128'(sp_tvalid), 128'(0));
    check({tag, "_rst_tready"}, 128'(nb_tready), 128'(0));
    check({tag, "_rst_tdata"}, 128'(sp_tdata), 128'(0));
    check({tag, "_rst_drop"}, 128'(drop_cnt), 128'(0));
    check({tag, "_rst_pulse"}, 128'(drop_pulse), 128'(0));
    check({tag, "_rst_trunc"}, 128'(trunc_cnt), 128'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_rdy_up"}, 128'(nb_tready), 128'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tv[9];
    beat_t b;
    int    s0;
    int    p0;
    int    o0;
    int    d0;

    tv[0] = '{8'h00, 8'hFF, 56'h0, 1'b1, 0};
    tv[1] = '{8'h08, 8'hFF, 56'h1234, 1'b1, 0};
    tv[2] = '{8'h09, 8'hFF, 56'h0, 1'b0, 1};
    tv[3] = '{8'h03, 8'hFF, 56'h77, 1'b1, 1};
    tv[4] = '{8'h01, 8'hFE, 56'h0, 1'b0, 2};
    tv[5] = '{8'hFF, 8'hFF, 56'h0, 1'b0, 3};
    tv[6] = '{8'h08, 8'h01, 56'h5A5A, 1'b1, 3};
    tv[7] = '{8'h10, 8'hFF, 56'h0, 1'b0, 4};
    tv[8] = '{8'h02, 8'hFF, 56'hABCD_0000_0000_FF, 1'b1, 4};

    reset_seq("init");

    // 3-beat legal packet, downstream ready; body type ignored
    drive(mk(8'h02, 8'hFF, 1'b0), 1'b1, 1'b0);
    check("t1_pre_valid", 128'(sp_tvalid), 128'(0));
    b = exp_q[0];
    drive(mk(8'hEE, 8'hFF, 1'b0), 1'b1, 1'b0);
    check("t1_latency", 128'(sp_tvalid), 128'(1));
    check("t1_first", 128'(sp_tdata), 128'(b.data));
    drive(mk(8'h33, 8'h0F, 1'b1), 1'b1, 1'b0);
    idle();
    drain();
    check("t1_drop", 128'(drop_cnt), 128'(0));

    // back-to-back single-beat packets from the table
    s0 = stalls;
    p0 = pulses;
    for (int i = 0; i < 9; i++) begin
      b = mk(tv[i].typ, tv[i].keep, 1'b1);
      b.data[63:8] = tv[i].hi;
      drive(b, tv[i].fwd, 1'b0);
      if (i > 0)
        check($sformatf("t2_cnt_%0d", i - 1), 128'(drop_cnt),
              128'(tv[i-1].cnt));
    end
    idle();
    @(negedge clk);
    check("t2_cnt_8", 128'(drop_cnt), 128'(tv[8].cnt));
    drain();
    check("t2_no_stall", 128'(stalls - s0), 128'(0));
    check("t2_pulses", 128'(pulses - p0), 128'(4));

    // illegal 4-beat packet while downstream is stalled
    ds_mode = 1;
    s0 = stalls;
    d0 = int'(drop_cnt);
    drive(mk(8'h05, 8'hFF, 1'b1), 1'b1, 1'b0);
    drive(mk(8'hFF, 8'hFF, 1'b0), 1'b0, 1'b0);
    drive(mk(8'h01, 8'hFF, 1'b0), 1'b0, 1'b0);
    drive(mk(8'h02, 8'hFF, 1'b0), 1'b0, 1'b0);
    drive(mk(8'h03, 8'hFF, 1'b1), 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("t3_no_stall", 128'(stalls - s0), 128'(0));
    check("t3_drop", 128'(drop_cnt), 128'(d0 + 1));
    check("t3_held_vld", 128'(sp_tvalid), 128'(1));
    check("t3_held_type", 128'(sp_tdata[7:0]), 128'(8'h05));
    ds_mode = 0;
    drain();

    // legal 5-beat packet with downstream toggling
    s0 = stalls;
    occ_m = 0;
    rdy_chk = 1'b1;
    tog = 1'b1;
    ds_mode = 2;
    for (int i = 0; i < 5; i++)
      drive(mk(8'h07, 8'hFF, 1'b0 | (i == 4)), 1'b1, 1'b0);
    idle();
    @(negedge clk);
    ds_mode = 0;
    drain();
    rdy_chk = 1'b0;
    check("t4_backpressure", 128'(stalls > s0), 128'(1));

    // reset after beat 2 of a 4-beat packet; beat 3 is a new head
    ds_mode = 1;
    drive(mk(8'h04, 8'hFF, 1'b0), 1'b1, 1'b0);
    drive(mk(8'h06, 8'hFF, 1'b0), 1'b1, 1'b0);
    @(negedge clk);
    ds_mode = 0;
    reset_seq("t5");
    p0 = pulses;
    o0 = outs;
    drive(mk(8'h01, 8'hFF, 1'b0), 1'b1, 1'b0);
    drive(mk(8'hC3, 8'hFF, 1'b1), 1'b1, 1'b0);
    idle();
    drain();
    check("t5_outs", 128'(outs - o0), 128'(2));
    check("t5_drop", 128'(drop_cnt), 128'(0));
    check("t5_pulses", 128'(pulses - p0), 128'(0));

    // reset in BODY, then an illegal head must still be dropped
    drive(mk(8'h03, 8'hFF, 1'b0), 1'b1, 1'b0);
    reset_seq("t5b");
    drive(mk(8'h20, 8'hFF, 1'b1), 1'b0, 1'b0);
    drive(mk(8'h03, 8'hFF, 1'b1), 1'b1, 1'b0);
    idle();
    drain();
    check("t5b_drop", 128'(drop_cnt), 128'(1));

    // drop counter saturation
    p0 = pulses;
    for (int i = 0; i < 16; i++)
      drive(mk(8'h80, 8'hFF, 1'b1), 1'b0, 1'b0);
    idle();
    @(negedge clk);
    @(negedge clk);
    check("sat_cnt", 128'(drop_cnt), 128'(15));
    check("sat_pulses", 128'(pulses - p0), 128'(16));

    // 6-beat legal packet against the length limit
    reset_seq("t6");
`ifdef RPN_INGRESS_MAX_LEN_CHECK_EN
    for (int i = 0; i < 6; i++)
      drive(mk(8'h02, 8'hFF, 1'b0 | (i == 5)), 1'b0 | (i < 4),
            1'b0 | (i == 3));
    drive(mk(8'h06, 8'hFF, 1'b1), 1'b1, 1'b0);
    idle();
    drain();
    check("t6_trunc", 128'(trunc_cnt), 128'(1));
`else
    for (int i = 0; i < 6; i++)
      drive(mk(8'h02, 8'hFF, 1'b0 | (i == 5)), 1'b1, 1'b0);
    idle();
    drain();
    check("t6_trunc", 128'(trunc_cnt), 128'(0));
`endif
    check("t6_drop", 128'(drop_cnt), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rpn_from_network_bridge_ingress_filter.md
Name: rpn_from_network_bridge_ingress_filter

Overview:
- Registered AXIS ingress stage between the network bridge output and the RPN WNN repo / WAN seq-num splitter.
- Buffers the stream in a 2-entry skid buffer so no combinational tready path crosses it; full throughput.
- Validates the RPN message type in the first beat of each packet and forwards only packets with a legal type.
- Discards illegal packets whole, without backpressuring the bridge, and counts them.

Parameters:
- AXIS_DATA_WIDTH, 64, tdata width.
- AXIS_KEEP_WIDTH, 8, tkeep width (AXIS_DATA_WIDTH/8).
- AXIS_FROM_NB_TDEST_WIDTH, 16, tid and tdest width.
- AXIS_FROM_NB_TUSER_WIDTH, 16, tuser width.
- RPN_MSG_TYPE_WIDTH, 8, message-type field width, located at tdata[RPN_MSG_TYPE_WIDTH-1:0] of the first beat.
- RPN_MSG_TYPE_MAX, 8, highest legal message type; legal range is 0..RPN_MSG_TYPE_MAX inclusive.
- DROP_CNT_WIDTH, 16, width of the drop and truncation counters.
- MAX_PKT_BEATS, 16, packet length limit; used only under the optional feature.

Ports:
- i_clk  in  1  clock.
- i_ap_rst  in  1  synchronous, active-high reset.
- from_network_bridge_tvalid/tready/tdata/tkeep/tid/tdest/tuser/tlast  in (tready out)  1/1/AXIS_DATA_WIDTH/AXIS_KEEP_WIDTH/AXIS_FROM_NB_TDEST_WIDTH x2/AXIS_FROM_NB_TUSER_WIDTH/1  AXIS slave from the network bridge.
- to_splitter_tvalid/tready/tdata/tkeep/tid/tdest/tuser/tlast  out (tready in)  same widths  AXIS master toward the splitter.
- o_drop_cnt  out  DROP_CNT_WIDTH  packets discarded; saturating.
- o_drop_pulse  out  1  one-cycle pulse when a discard begins.
- o_trunc_cnt  out  DROP_CNT_WIDTH  packets truncated; optional feature only.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_ap_rst is synchronous and active-high.
- Reset values:
  - to_splitter_tvalid=0.
  - from_network_bridge_tready=0 during reset; becomes 1 in the first cycle after reset deasserts.
  - o_drop_cnt=0, o_drop_pulse=0, o_trunc_cnt=0.
  - FSM=HEAD; skid buffer empty.
  - Data outputs reset to 0.
- Handshake:
  - A beat transfers when tvalid && tready.
  - from_network_bridge_tready is a registered signal: 1 iff skid occupancy < 2, or FSM is DROP.
  - to_splitter_tvalid, once asserted, is held with stable data until tready.
- Latency: 1 cycle from an accepted input beat to to_splitter_tvalid when the buffer is empty. Sustained throughput is 1 beat/cycle when downstream is always ready.
- FSM:
  - HEAD: waiting for the first beat of a packet.
    - Legal if tdata[RPN_MSG_TYPE_WIDTH-1:0] <= RPN_MSG_TYPE_MAX and tkeep[0]==1.
    - Legal beat: push to the skid buffer; go to BODY if tlast==0, stay in HEAD if tlast==1.
    - Illegal beat: do not push; o_drop_pulse=1 next cycle; o_drop_cnt+1 (saturates at all-ones); go to DROP if tlast==0, stay in HEAD if tlast==1.
  - BODY: push every accepted beat unmodified; return to HEAD on tlast.
  - DROP: accept and discard every beat with tready=1 regardless of downstream state; return to HEAD on tlast.
- Beat contents: tdata, tkeep, tid, tdest, tuser and tlast are forwarded bit-exact; the block never alters beats.
- Boundary conditions:
  - Single-beat illegal packet: dropped and counted; FSM stays in HEAD.
  - Buffer full in HEAD or BODY: tready=0. In DROP, tready stays 1 even with a full buffer; the buffer drains independently.
  - Downstream stall while dropping: no effect on discard progress.
  - Reset mid-packet: buffer flushed; the FSM returns to HEAD, so the next beat is treated as a packet head.
  - Counter saturation: a drop at all-ones still pulses o_drop_pulse; the count holds.

Optional Feature:
- Macro: RPN_INGRESS_MAX_LEN_CHECK_EN.
- Defined:
  - A beat counter runs in BODY.
  - On beat number MAX_PKT_BEATS of a forwarded packet, tlast is forced to 1 on output and o_trunc_cnt increments (saturating).
  - The FSM then enters DROP unless the input beat already had tlast.
- Undefined: no length limit; o_trunc_cnt tied to 0; the beat counter is not synthesised.

Test Plan:
- Reset, then one 3-beat packet with type=2 and downstream always ready -> 3 output beats, bit-exact, first output 1 cycle after first input, tlast on beat 3, o_drop_cnt=0.
- Back-to-back 1-beat packets with types 0, 8, 9, 3 -> output types 0, 8, 3; o_drop_cnt=1; one o_drop_pulse; input tready never drops.
- 4-beat packet with type=0xFF while downstream tready=0 throughout -> all 4 beats accepted in 4 consecutive cycles, nothing output, o_drop_cnt=1.
- Legal 5-beat packet with downstream tready toggling 1,0,1,0 -> no beat lost or duplicated, data stable while stalled, input tready deasserts only when 2 beats are buffered.
- Reset pulsed after beat 2 of a 4-beat legal packet, then remaining beats 3-4 presented, with beat 3 holding type=1 and tlast on beat 4 -> beat 3 treated as head; 2 beats output, ending with tlast; counters=0.
- With RPN_INGRESS_MAX_LEN_CHECK_EN and MAX_PKT_BEATS=4, a 6-beat legal packet -> 4 beats output with tlast forced on beat 4, beats 5-6 discarded, o_trunc_cnt=1, o_drop_cnt=0.
